// File: rtl/wave_mixer.sv
// Serial MAC mixer: sums NUM_CH volume-scaled channels, one channel per clock, then applies
// master volume with saturation. O_VALID pulses NUM_CH+2 clocks after the trigger edge.
module wave_mixer #(
  parameter int NUM_CH = 8,
  parameter int ACC_W  = 28,
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 I_CLK,
  input  logic                 I_RSTn,
  input  logic [NUM_CH*16-1:0] I_SND_CH,
  input  logic [NUM_CH-1:0]    I_CH_EN,
  input  logic [NUM_CH-1:0]    I_CH_8BIT,
  input  logic                 I_VOL_WE,
  input  logic [IDX_W-1:0]     I_VOL_CH,
  input  logic [7:0]           I_VOL_DATA,
  input  logic [7:0]           I_MASTER_VOL,
  input  logic                 I_MIX_TRIG,
  input  logic                 I_CLIP_CLR,
  output logic [15:0]          O_SND,
  output logic                 O_VALID,
  output logic                 O_BUSY,
  output logic                 O_CLIP,
  output logic                 O_OVERRUN
);

  typedef enum logic [1:0] {IDLE, ACC, SCALE, OUT} state_t;

  localparam logic signed [ACC_W+8:0] SAT_HI = (ACC_W+9)'(32767);
  localparam logic signed [ACC_W+8:0] SAT_LO = (ACC_W+9)'(-32768);

  state_t state_q, state_d;

  logic [7:0]              vol_q [NUM_CH];
  logic [7:0]              vol_s [NUM_CH];
  logic [NUM_CH*16-1:0]    snd_s;
  logic [NUM_CH-1:0]       en_s;
  logic [NUM_CH-1:0]       b8_s;
  logic [7:0]              mst_s;
  logic [IDX_W-1:0]        idx_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [15:0]             sat_q;

  logic [15:0]             raw;
  logic signed [15:0]      s_cur;
  logic signed [8:0]       v_cur;
  logic signed [24:0]      prod;
  logic signed [ACC_W-1:0] acc_add;
  logic signed [ACC_W+8:0] acc_x, mst_x, p, r;
  logic [15:0]             sat_d;
  logic                    clip_hit;
  logic                    trig_busy;

  assign O_BUSY    = (state_q != IDLE);
  assign trig_busy = I_MIX_TRIG && (state_q != IDLE);

  // Current term: converted sample of channel idx times its unsigned volume
  assign raw = snd_s[16*idx_q +: 16];
  always_comb begin
    s_cur = '0;
    if (en_s[idx_q])
      s_cur = b8_s[idx_q] ? {~raw[7], raw[6:0], 8'h00} : raw;
  end
  assign v_cur   = {1'b0, vol_s[idx_q]};
  assign prod    = s_cur * v_cur;
  assign acc_add = acc_q + {{(ACC_W-25){prod[24]}}, prod};

  assign acc_x = {{9{acc_q[ACC_W-1]}}, acc_q};
  assign mst_x = {{ACC_W{1'b0}}, mst_s};
  assign p     = acc_x * mst_x;
  assign r     = p >>> 14;

  always_comb begin
    sat_d    = r[15:0];
    clip_hit = 1'b0;
    if (r > SAT_HI) begin
      sat_d    = 16'h7FFF;
      clip_hit = 1'b1;
    end else if (r < SAT_LO) begin
      sat_d    = 16'h8000;
      clip_hit = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int k = 0; k < NUM_CH; k++) vol_q[k] <= 8'h80;
    end else if (I_VOL_WE) begin
      vol_q[I_VOL_CH] <= I_VOL_DATA;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_MIX_TRIG) state_d = ACC;
      ACC:     if (idx_q == IDX_W'(NUM_CH-1)) state_d = SCALE;
      SCALE:   state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      for (int k = 0; k < NUM_CH; k++) vol_s[k] <= 8'h80;
      snd_s     <= '0;
      en_s      <= '0;
      b8_s      <= '0;
      mst_s     <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      sat_q     <= '0;
      O_SND     <= '0;
      O_VALID   <= 1'b0;
      O_CLIP    <= 1'b0;
      O_OVERRUN <= 1'b0;
    end else begin
      O_VALID <= 1'b0;
      case (state_q)
        IDLE: begin
          if (I_MIX_TRIG) begin
            for (int k = 0; k < NUM_CH; k++) vol_s[k] <= vol_q[k];
            snd_s <= I_SND_CH;
            en_s  <= I_CH_EN;
            b8_s  <= I_CH_8BIT;
            mst_s <= I_MASTER_VOL;
            acc_q <= '0;
            idx_q <= '0;
          end
        end
        ACC: begin
          acc_q <= acc_add;
          idx_q <= idx_q + 1'b1;
        end
        SCALE: sat_q <= sat_d;
        OUT: begin
          O_SND   <= sat_q;
          O_VALID <= 1'b1;
        end
        default: ;
      endcase
      // Set beats clear when both happen in the same clock
      if (state_q == SCALE && clip_hit) O_CLIP <= 1'b1;
      else if (I_CLIP_CLR)              O_CLIP <= 1'b0;
      if (trig_busy)                    O_OVERRUN <= 1'b1;
      else if (I_CLIP_CLR)              O_OVERRUN <= 1'b0;
    end
  end

endmodule

// File: doc/wave_mixer.md
Name: wave_mixer

Overview:
Downstream stage for the wave sample players. Mixes up to NUM_CH signed 16-bit channel outputs into one signed 16-bit stream once per sample strobe, applying per-channel and master volume. Uses a serial multiply-accumulate (one channel per clock) and saturates the result with a sticky clip flag. Feeds the audio output path.

Parameters:
NUM_CH, 8, number of mixed channels (power of 2, at most 16)
ACC_W, 28, signed accumulator width; must be at least 16+9+log2(NUM_CH)

Ports:
I_CLK  in  1  system clock
I_RSTn  in  1  asynchronous active-low reset
I_SND_CH  in  NUM_CH*16  packed channel samples, ch k at [16k+15:16k], signed
I_CH_EN  in  NUM_CH  per-channel enable; 0 means the channel contributes 0
I_CH_8BIT  in  NUM_CH  1 means the channel carries {8'h00, unsigned byte}
I_VOL_WE  in  1  per-channel volume write strobe
I_VOL_CH  in  log2(NUM_CH)  channel index for the volume write
I_VOL_DATA  in  8  volume value; 0x80 = unity
I_MASTER_VOL  in  8  master volume; 0x80 = unity
I_MIX_TRIG  in  1  output-rate sample strobe, one clock wide
I_CLIP_CLR  in  1  clears O_CLIP and O_OVERRUN
O_SND  out  16  mixed sample, signed, held between updates
O_VALID  out  1  one-clock pulse when O_SND updates
O_BUSY  out  1  high in any state other than IDLE
O_CLIP  out  1  sticky flag: saturation has occurred
O_OVERRUN  out  1  sticky flag: a trigger arrived while busy

Behaviour:
- Reset (asynchronous, takes effect at any time, including mid-mix): O_SND=0, O_VALID=0, O_BUSY=0, O_CLIP=0, O_OVERRUN=0. All volume registers = 0x80. FSM goes to IDLE. Accumulator and index = 0.
- Volume register file: on any clock with I_VOL_WE=1, vol[I_VOL_CH] <= I_VOL_DATA, regardless of FSM state.
- FSM states: IDLE, ACC, SCALE, OUT.
- IDLE:
  - When I_MIX_TRIG=1, snapshot every channel's sample, enable, 8-bit flag and vol[k], plus I_MASTER_VOL.
  - acc <= 0, idx <= 0, go to ACC.
  - Later changes to inputs or volumes do not affect this mix.
- Sample conversion:
  - 8-bit channel: s = {byte[7]^1, byte[6:0], 8'h00}, e.g. 0x80 -> 0, 0xFF -> 0x7F00, 0x00 -> 0x8000.
  - 16-bit channel: used as is.
  - Disabled channel: s = 0.
- ACC: once per clock, acc <= acc + s[idx] * {1'b0, vol[idx]}.
  - Signed 16 x signed 9 product, sign-extended to ACC_W.
  - idx increments each clock. After the idx=NUM_CH-1 term, go to SCALE.
- SCALE:
  - p = acc * {1'b0, master}, computed at ACC_W+9 bits.
  - r = p >>> 14 (arithmetic shift, floor toward minus infinity).
  - If r > 32767, sat = 0x7FFF. If r < -32768, sat = 0x8000. In either case set O_CLIP.
  - Otherwise sat = r[15:0]. Go to OUT.
- OUT: O_SND <= sat, O_VALID=1 for this single clock, then go to IDLE.
- Latency: with the trigger sampled at edge E, O_VALID is high in the cycle after edge E+NUM_CH+2. That is 10 clocks for NUM_CH=8.
- Trigger while O_BUSY=1: the trigger is ignored, O_OVERRUN is set, and the current mix is unaffected.
- A trigger in the same clock as the OUT->IDLE transition counts as busy.
- I_CLIP_CLR: clears both sticky flags. If a set event occurs in the same clock, set wins.
- Volume write in the same clock as the snapshot: the snapshot takes the old value. The new value applies from the next mix.

Test Plan:
- Unity: ch0=0x1000, I_CH_EN=0x01, vol0=0x80, master=0x80, trigger -> O_VALID exactly 10 clocks later, O_SND=0x1000, O_CLIP=0.
- Positive saturation: all 8 channels 0x7000, enabled, unity volumes -> O_SND=0x7FFF, O_CLIP=1. Then pulse I_CLIP_CLR -> O_CLIP=0.
- Negative saturation and floor:
  - ch0=ch1=0x8000, unity -> O_SND=0x8000, O_CLIP=1.
  - ch0=0xFFFF, master=0x40 -> O_SND=0xFFFF (floor of -0.5).
- 8-bit conversion: ch2=0x00FF with I_CH_8BIT[2]=1 -> 0x7F00. ch2=0x0080 -> 0x0000. ch2=0x0000 -> 0x8000.
- Volumes and snapshot:
  - ch0=0x1000, vol0=0x40 -> 0x0800.
  - Write vol0=0x80 in the same clock as the trigger -> still 0x0800; the next mix gives 0x1000.
- Overrun and reset: trigger at clock 0 and again at clock 4 -> exactly one O_VALID, O_OVERRUN=1. Assert I_RSTn=0 during ACC -> O_SND=0, O_BUSY=0, no O_VALID, vol registers back to 0x80.
